// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode constants, ifetch state encoding and
// the branch-offset helper used by the next-PC logic.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } ifetch_state_t;

    // Word-scaled, sign-extended branch displacement from a 16-bit immediate.
    function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
        logic signed [31:0] off;
        off = {{14{imm[15]}}, imm, 2'b00};
        return off;
    endfunction

endpackage

// File: rtl/ifetch_nextpc.sv
// Next-PC selection for the fetch unit: jump beats taken branch beats PC+4.
// All additions wrap modulo 2^32.
module ifetch_nextpc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] next_pc
);

    logic signed [31:0] br_off;
    logic               unused_opfield;

    assign br_off         = branch_offset(instr[15:0]);
    assign unused_opfield = ^instr[31:26];

    // Priority select of the successor address.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + $unsigned(br_off);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: holds the PC, fetches words over a req/ready
// handshake and presents the instruction/opcode to the decoder.
// Optional build macro IFETCH_PERF_EN adds retire and wait-cycle counters.
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          AW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic [31:0]   imem_rdata,
    output logic [31:0]   instr,
    output logic [5:0]    op,
    output logic          instr_valid,
    input  logic          stall,
    input  logic          branch,
    input  logic          zero,
    input  logic          jump,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus4
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]   perf_retired,
    output logic [31:0]   perf_wait
`endif
);

    ifetch_state_t state, state_next;
    logic          req_next;
    logic          valid_next;
    logic          capture;
    logic          retire;
    logic [31:0]   next_pc;

    assign imem_addr = pc;
    assign op        = instr[31:26];
    assign pc_plus4  = pc + 32'd4;

    ifetch_nextpc u_nextpc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .next_pc  (next_pc)
    );

    // Next-state and handshake control; feedback is only consumed at retire.
    always_comb begin
        state_next = state;
        req_next   = imem_req;
        valid_next = instr_valid;
        capture    = 1'b0;
        retire     = 1'b0;
        case (state)
            FETCH: begin
                req_next = 1'b1;
                if (imem_req && imem_ready) begin
                    capture    = 1'b1;
                    valid_next = 1'b1;
                    req_next   = 1'b0;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                req_next = 1'b0;
                if (!stall) begin
                    retire     = 1'b1;
                    valid_next = 1'b0;
                    req_next   = 1'b1;
                    state_next = FETCH;
                end
            end
            default: begin
                req_next   = 1'b0;
                valid_next = 1'b0;
                state_next = FETCH;
            end
        endcase
    end

    // State, PC and instruction registers; reset aborts any fetch in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            pc          <= RESET_PC;
            instr       <= 32'd0;
        end else begin
            state       <= state_next;
            imem_req    <= req_next;
            instr_valid <= valid_next;
            if (capture) begin
                instr <= imem_rdata;
            end
            if (retire) begin
                pc <= next_pc;
            end
        end
    end

`ifdef IFETCH_PERF_EN
    // Retired-instruction and memory-wait counters, both free-running and wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_retired <= 32'd0;
            perf_wait    <= 32'd0;
        end else begin
            if (retire) begin
                perf_retired <= perf_retired + 32'd1;
            end
            if (state == FETCH && !imem_ready) begin
                perf_wait <= perf_wait + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: stimulus pushes expected fetch addresses
// and captured instructions; a negedge monitor pops and compares them.
module tb_ifetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic        instr_valid;
    logic        stall;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_wait;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } cap_t;

    logic [31:0] addr_q[$];
    cap_t        cap_q[$];

    int tests;
    int fails;

    logic        prev_valid;
    logic [31:0] held_instr;
    logic [31:0] held_pc;

    ifetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .op          (op),
        .instr_valid (instr_valid),
        .stall       (stall),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
`ifdef IFETCH_PERF_EN
        ,
        .perf_retired(perf_retired),
        .perf_wait   (perf_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: fetch addresses while requesting, instruction fields on capture,
    // and stability of the held instruction throughout EXEC.
    always @(negedge clk) begin
        cap_t c;
        if (!reset) begin
            if (imem_req && imem_ready) begin
                if (addr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
                end else begin
                    check("fetch_addr", imem_addr, addr_q.pop_front());
                end
            end else if (imem_req && addr_q.size() != 0) begin
                check("wait_addr", imem_addr, addr_q[0]);
                check("wait_valid", {31'd0, instr_valid}, 32'd0);
            end
            if (instr_valid && !prev_valid) begin
                if (cap_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL capture_unexpected: got instr %h expected none", instr);
                end else begin
                    c = cap_q.pop_front();
                    check("cap_instr", instr, c.data);
                    check("cap_op", {26'd0, op}, {26'd0, c.data[31:26]});
                    check("cap_pc", pc, c.addr);
                    check("cap_pc_plus4", pc_plus4, c.addr + 32'd4);
                    held_instr = c.data;
                    held_pc    = c.addr;
                end
            end else if (instr_valid) begin
                check("hold_instr", instr, held_instr);
                check("hold_op", {26'd0, op}, {26'd0, held_instr[31:26]});
                check("hold_pc", pc, held_pc);
                check("exec_req", {31'd0, imem_req}, 32'd0);
            end
        end
        prev_valid = reset ? 1'b0 : instr_valid;
    end

    // One instruction: fetch at addr (with optional wait cycles), optional
    // stall cycles carrying junk feedback, then retire with br/z/j.
    task automatic fetch_exec(input logic [31:0] addr, input logic [31:0] data,
                              input int waits, input logic br, input logic z,
                              input logic j, input int stalls);
        int n;
        cap_t c;
        c.addr = addr;
        c.data = data;
        addr_q.push_back(addr);
        cap_q.push_back(c);
        imem_rdata = data;
        imem_ready = 1'b0;
        n = 0;
        while (!imem_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!imem_req) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: got imem_req 0 expected 1 for addr %h", addr);
            return;
        end
        for (int w = 0; w < waits; w++) begin
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b1;
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        for (int s = 0; s < stalls; s++) begin
            stall  = 1'b1;
            branch = s[0];
            zero   = 1'b1;
            jump   = ~s[0];
            @(posedge clk);
            #1;
        end
        stall  = 1'b0;
        branch = br;
        zero   = z;
        jump   = j;
        @(posedge clk);
        #1;
        branch = 1'b0;
        zero   = 1'b0;
        jump   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        tests      = 0;
        fails      = 0;
        prev_valid = 1'b0;
        held_instr = 32'd0;
        held_pc    = 32'd0;
        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        stall      = 1'b0;
        branch     = 1'b0;
        zero       = 1'b0;
        jump       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc", pc, 32'h0000_0000);
        check("rst_instr", instr, 32'd0);
`ifdef IFETCH_PERF_EN
        check("rst_perf_retired", perf_retired, 32'd0);
        check("rst_perf_wait", perf_wait, 32'd0);
`endif
        reset = 1'b0;
        #1;
        check("req_after_release", {31'd0, imem_req}, 32'd0);

        // Sequential flow, wait states, beq taken/not taken, stall, branch without zero-gate
        fetch_exec(32'h0000_0000, 32'h8C08_0004, 0, 1'b0, 1'b0, 1'b0, 0);
        fetch_exec(32'h0000_0004, 32'h2008_0005, 0, 1'b0, 1'b0, 1'b0, 0);
        fetch_exec(32'h0000_0008, 32'h3508_00FF, 3, 1'b0, 1'b0, 1'b0, 0);
        fetch_exec(32'h0000_000C, 32'h0109_4020, 0, 1'b0, 1'b0, 1'b0, 0);
        fetch_exec(32'h0000_0010, 32'h1109_FFFC, 0, 1'b1, 1'b0, 1'b0, 0);
        fetch_exec(32'h0000_0014, 32'h1000_FFFE, 0, 1'b1, 1'b1, 1'b0, 0);
        fetch_exec(32'h0000_0010, 32'h1109_FFFC, 0, 1'b1, 1'b1, 1'b0, 5);
        fetch_exec(32'h0000_0004, 32'h1000_FFFF, 0, 1'b0, 1'b1, 1'b0, 0);
        fetch_exec(32'h0000_0008, 32'h0800_0010, 0, 1'b0, 1'b0, 1'b1, 0);

        // Reset in the middle of the fetch at 0x40
        check("jump_to_40_addr", imem_addr, 32'h0000_0040);
        check("jump_to_40_req", {31'd0, imem_req}, 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_req", {31'd0, imem_req}, 32'd0);
        check("abort_valid", {31'd0, instr_valid}, 32'd0);
        check("abort_pc", pc, 32'h0000_0000);
        check("abort_instr", instr, 32'd0);
`ifdef IFETCH_PERF_EN
        check("abort_perf_retired", perf_retired, 32'd0);
        check("abort_perf_wait", perf_wait, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Restart at RESET_PC, wrap through 0xFFFF_FFFC, cross into upper nibble 1, jump there
        fetch_exec(32'h0000_0000, 32'h1000_FFFE, 0, 1'b1, 1'b1, 1'b0, 0);
        fetch_exec(32'hFFFF_FFFC, 32'h0109_4020, 0, 1'b0, 1'b0, 1'b0, 0);
        fetch_exec(32'h0000_0000, 32'h0BFF_FFFE, 0, 1'b0, 1'b0, 1'b1, 0);
`ifdef IFETCH_PERF_EN
        check("perf_retired_3", perf_retired, 32'd3);
`endif
        fetch_exec(32'h0FFF_FFF8, 32'h0109_4020, 0, 1'b0, 1'b0, 1'b0, 0);
        fetch_exec(32'h0FFF_FFFC, 32'h3108_0001, 0, 1'b0, 1'b0, 1'b0, 0);
        fetch_exec(32'h1000_0000, 32'h1000_0007, 0, 1'b1, 1'b1, 1'b0, 0);
        fetch_exec(32'h1000_0020, 32'h0800_0040, 0, 1'b1, 1'b1, 1'b1, 0);
        fetch_exec(32'h1000_0100, 32'h2908_0003, 1, 1'b0, 1'b0, 1'b0, 2);
        fetch_exec(32'h1000_0104, 32'hAD08_0000, 0, 1'b0, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        check("cap_q_drained", 32'(cap_q.size()), 32'd0);
        check("final_pc", pc, 32'h1000_0108);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch front end that sources the 6-bit opcode and instruction word for the main decoder.
- Holds the PC and issues word fetches to instruction memory over a req/ready handshake.
- Presents each fetched instruction to the decoder as op = instr[31:26].
- Computes the next PC from the branch, zero and jump feedback returned by the decoder/ALU.
- Sits between the instruction memory and the control path (maindec/aludec) of the MIPS core.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- AW, 32, PC/address width; the jump target uses the PC+4 upper 4 bits, so AW is fixed at 32.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request; held high until accepted.
- imem_addr  output  32  fetch address; equals pc while imem_req is high.
- imem_ready  input  1  memory accepts the request and returns data in the same cycle.
- imem_rdata  input  32  instruction word, valid when imem_req && imem_ready.
- instr  output  32  registered current instruction.
- op  output  6  instr[31:26], the opcode to the decoder.
- instr_valid  output  1  instr/op/pc describe a live instruction.
- stall  input  1  core not ready to retire the current instruction.
- branch  input  1  decoder branch control for the current instruction.
- zero  input  1  ALU zero flag for the current instruction.
- jump  input  1  decoder jump control for the current instruction.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc + 4.

Behaviour:
- Reset (async): pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, imem_req=0.
- imem_req is a registered output that goes high on the first clk edge after reset deasserts.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc. On imem_ready, capture instr<=imem_rdata, set instr_valid<=1 and move to EXEC. Otherwise stay in FETCH with the address held stable.
  - EXEC: imem_req=0, instr_valid=1. If stall=1, hold everything. If stall=0 (retire), update pc<=next_pc, drop instr_valid<=0 and return to FETCH.
- next_pc priority, evaluated at retire:
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else branch && zero: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), modulo 2^32.
  - else: pc_plus4.
- Minimum throughput: one instruction every 2 cycles, with a 1-cycle FETCH when memory is ready immediately.
- Arithmetic wraps: pc 32'hFFFF_FFFC + 4 gives 0.
- branch, zero and jump are sampled only in EXEC when stall=0 and are ignored otherwise.
- jump && branch together: jump wins.
- instr and op stay stable for the whole of EXEC, including across stalls.
- Reset asserted mid-FETCH or mid-EXEC aborts immediately: imem_req drops asynchronously and the captured instruction is discarded.
- op = 0 (R-type) and every other opcode pass through unmodified; the unit does no decoding beyond the next-PC fields.

Optional Feature:
Macro IFETCH_PERF_EN.
- Defined: adds outputs perf_retired[31:0] and perf_wait[31:0], both reset to 0.
  - perf_retired increments on each retire.
  - perf_wait increments on each FETCH cycle with imem_ready=0.
  - Both counters wrap at 2^32.
- Undefined: neither the ports nor the counter logic exist; all other behaviour is identical.

Decomposition:
- Shared mips_pkg holds:
  - opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_ADDI=6'b001000, OP_J=6'b000010, OP_ANDI=6'b001100, OP_ORI=6'b001101, OP_SLTI=6'b001010;
  - the ifetch state encoding (FETCH, EXEC).
- One combinational sub-module, ifetch_nextpc (inputs pc_plus4, instr, branch, zero, jump; output next_pc), is natural so the next-PC rule can be unit-tested alone.

Test Plan:
1. Reset release, imem_ready=1, imem_rdata=32'h8C08_0004 (lw), stall=0 -> imem_addr=0, then op=6'b100011 with instr_valid=1, then imem_addr=4.
2. Wait states: imem_ready low for 3 cycles at pc=8 -> imem_req stays high with imem_addr=8 throughout; instr_valid stays 0 until ready rises.
3. beq at pc=0x10, imm=16'hFFFC, branch=1, zero=1 -> next fetch at 0x04. Same instruction with zero=0 -> next fetch at 0x14.
4. j at pc=0x1000_0020 with instr=32'h0800_0040 -> next fetch at 0x1000_0100. With jump=1 and branch=1 together, the jump target is still taken.
5. stall=1 for 5 cycles in EXEC -> instr, op and pc unchanged and imem_req=0; toggling branch/zero/jump has no effect until stall drops.
6. Reset asserted mid-FETCH while pc=0x40 -> imem_req=0 and instr_valid=0 at once; after release, fetch restarts at RESET_PC. With IFETCH_PERF_EN defined, counters read 0 after reset and perf_retired=3 after 3 retires.
